// File: rtl/add_mul_pkg.sv
// Shared definitions for the add_mul pipeline and its downstream credit buffer.
package add_mul_pkg;

  localparam int unsigned ADD_MUL_DATA_W  = 32;
  localparam int unsigned ADD_MUL_LATENCY = 3;

  typedef logic [ADD_MUL_DATA_W-1:0] add_mul_result_t;

endpackage

// File: rtl/add_mul_result_fifo.sv
// Circular result buffer: synchronous write, registered read/write pointers and occupancy count.
module add_mul_result_fifo
  import add_mul_pkg::*;
#(
  parameter  int unsigned DATA_W = ADD_MUL_DATA_W,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned PW     = $clog2(DEPTH),
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CW-1:0]     count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pop;

  assign pop     = pop_i & (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Explicit wrap so non-power-of-two depths index correctly.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_i) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({wr_en_i, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/add_mul_credit_buffer.sv
// Credit-throttled capture buffer behind the fixed-latency add_mul pipeline.
// Optional high-water-mark port enabled by defining ADD_MUL_CREDIT_BUF_HWM_EN.
module add_mul_credit_buffer
  import add_mul_pkg::*;
#(
  parameter  int unsigned DATA_W  = ADD_MUL_DATA_W,
  parameter  int unsigned LATENCY = ADD_MUL_LATENCY,
  parameter  int unsigned DEPTH   = 8,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pipe_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef ADD_MUL_CREDIT_BUF_HWM_EN
  ,
  output logic [CW-1:0]     hwm
`endif
);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [CW-1:0]      credits_q, credits_d;
  logic [CW-1:0]      fifo_count;
  logic               in_fire;
  logic               out_fire;
  logic               capture;

  // in_ready depends only on registered credits: no path from out_ready/in_valid.
  assign in_ready  = (credits_q != '0);
  assign in_fire   = in_valid & in_ready;
  assign out_valid = (fifo_count != '0);
  assign out_fire  = out_valid & out_ready;
  assign capture   = vld_q[LATENCY-1];

  always_comb begin
    vld_d    = '0;
    vld_d[0] = in_fire;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_comb begin
    credits_d = credits_q;
    case ({in_fire, out_fire})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      credits_q <= CW'(DEPTH);
    end else begin
      vld_q     <= vld_d;
      credits_q <= credits_d;
    end
  end

  add_mul_result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (capture),
    .wr_data_i (pipe_out),
    .pop_i     (out_fire),
    .head_o    (out_data),
    .count_o   (fifo_count)
  );

`ifdef ADD_MUL_CREDIT_BUF_HWM_EN
  logic [CW-1:0] hwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q <= '0;
    end else if (fifo_count > hwm_q) begin
      hwm_q <= fifo_count;
    end
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_add_mul_credit_buffer.sv
// Directed self-checking bench for add_mul_credit_buffer with a behavioural 3-stage pipeline model.
module tb_add_mul_credit_buffer;
  import add_mul_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LAT   = 3;
  localparam int unsigned CW    = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready = 1'b0;
  add_mul_result_t pipe_out = '0;
  add_mul_result_t out_data;
`ifdef ADD_MUL_CREDIT_BUF_HWM_EN
  logic [CW-1:0]   hwm;
`endif

  add_mul_credit_buffer #(
    .DATA_W  (32),
    .LATENCY (LAT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pipe_out  (pipe_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef ADD_MUL_CREDIT_BUF_HWM_EN
    ,
    .hwm       (hwm)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  add_mul_result_t sb[$];
  add_mul_result_t s1 = '0, s2 = '0, s3 = '0;
  add_mul_result_t fire_val = '0;
  int unsigned     issue_n = 0;
  int              fires = 0;
  int              pops = 0;
  logic            lf = 1'b0;
  logic            lo = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the pipeline model shifts fired operands, garbage elsewhere.
  task automatic step();
    @(posedge clk);
    #1;
    s3 = s2;
    s2 = s1;
    s1 = lf ? fire_val : add_mul_result_t'($urandom);
    pipe_out = s3;
  endtask

  task automatic cyc(input logic iv, input logic ordy);
    add_mul_result_t exp_v;
    in_valid  = iv;
    out_ready = ordy;
    #1;
    lf = iv & in_ready;
    lo = out_valid & ordy;
    if (lf) begin
      fire_val = 32'h15 + (issue_n << 8);
      sb.push_back(fire_val);
      issue_n++;
      fires++;
    end
    if (lo) begin
      pops++;
      if (sb.size() == 0) begin
        chk("spurious_pop", 1, 0);
      end else begin
        exp_v = sb.pop_front();
        chk("order", out_data, exp_v);
      end
    end
    chk("credit_inv",
        64'(int'(dut.credits_q) + int'(dut.fifo_count) + $countones(dut.vld_q)), DEPTH);
    step();
  endtask

  int vcount;
  int stalls;
  int first_pop;
  int c;

  initial begin
    // Reset values under random inputs
    in_valid  = 1'($urandom);
    out_ready = 1'($urandom);
    pipe_out  = add_mul_result_t'($urandom);
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
`ifdef ADD_MUL_CREDIT_BUF_HWM_EN
    chk("rst_hwm", hwm, 0);
`endif
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single issue: result visible exactly in cycle 4
    chk("single_c0_vld", out_valid, 0);
    cyc(1'b1, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      chk("single_vld", out_valid, (k == 4));
      if (k == 4) chk("single_data", out_data, 32'h15);
      cyc(1'b0, 1'b1);
    end
    chk("single_sb_empty", sb.size(), 0);

    // Backpressure fill then drain
    fires = 0;
    pops  = 0;
    repeat (14) cyc(1'b1, 1'b0);
    chk("bp_fires", fires, 8);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_count", dut.fifo_count, 8);
`ifdef ADD_MUL_CREDIT_BUF_HWM_EN
    chk("bp_hwm", hwm, 8);
`endif
    chk("bp_rdy_before_pop", in_ready, 0);
    cyc(1'b0, 1'b1);
    chk("bp_rdy_after_pop", in_ready, 1);
    repeat (9) cyc(1'b0, 1'b1);
    chk("bp_pops", pops, 8);
    chk("bp_drained", out_valid, 0);
    chk("bp_sb_empty", sb.size(), 0);

    // Random concurrency with pointer wrap
    repeat (200) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (12) cyc(1'b0, 1'b1);
    chk("rand_sb_empty", sb.size(), 0);
    chk("rand_out_valid", out_valid, 0);
    chk("rand_wr_ptr", dut.u_fifo.wr_ptr_q, issue_n % DEPTH);
    chk("rand_rd_ptr", dut.u_fifo.rd_ptr_q, issue_n % DEPTH);

    // Full throughput
    fires = 0;
    pops = 0;
    stalls = 0;
    first_pop = -1;
    for (c = 0; c < 100; c++) begin
      if (!in_ready) stalls++;
      cyc(1'b1, 1'b1);
      if (lo && first_pop < 0) first_pop = c;
    end
    for (; c < 110; c++) begin
      cyc(1'b0, 1'b1);
      if (lo && first_pop < 0) first_pop = c;
    end
    chk("tp_stalls", stalls, 0);
    chk("tp_fires", fires, 100);
    chk("tp_pops", pops, 100);
    chk("tp_first_pop", first_pop, 4);

    // Reset mid-flight discards in-flight issues
    repeat (3) cyc(1'b1, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_credits", dut.credits_q, DEPTH);
`ifdef ADD_MUL_CREDIT_BUF_HWM_EN
    chk("mid_rst_hwm", hwm, 0);
`endif
    #3 rst_n = 1'b1;
    sb.delete();
    lf = 1'b0;
    step();
    vcount = 0;
    repeat (8) begin
      if (out_valid) vcount++;
      cyc(1'b0, 1'b1);
    end
    chk("mid_no_valid", vcount, 0);
    chk("mid_credits", dut.credits_q, DEPTH);
    chk("mid_in_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
